// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control unit (mc_ctrl).
package mc_pkg;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXE, S_MEM, S_WB, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    C_RTYPE, C_JR, C_ORI, C_LUI, C_ADDIU, C_LW, C_SW, C_BEQ, C_J, C_JAL, C_ILL
  } cls_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [1:0] NPC_PC4  = 2'b00;
  localparam logic [1:0] NPC_BR   = 2'b01;
  localparam logic [1:0] NPC_JUMP = 2'b10;
  localparam logic [1:0] NPC_JR   = 2'b11;

  localparam logic [1:0] GPR_RD   = 2'b00;
  localparam logic [1:0] GPR_RT   = 2'b01;
  localparam logic [1:0] GPR_31   = 2'b10;

  localparam logic [1:0] WD_ALU   = 2'b00;
  localparam logic [1:0] WD_DM    = 2'b01;
  localparam logic [1:0] WD_PC    = 2'b10;

  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;
  localparam logic [1:0] EXT_LUI  = 2'b10;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_SLT  = 3'b100;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decode: op/funct -> class, ALU/extend controls, illegal flag.
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] i_op,
  input  logic [5:0] i_funct,
  output cls_t       o_cls,
  output logic [2:0] o_alu_op,
  output logic [1:0] o_ext_op,
  output logic       o_bsel,
  output logic       o_illegal
);

  // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    o_cls    = C_ILL;
    o_alu_op = ALU_ADD;
    o_ext_op = EXT_ZERO;
    o_bsel   = 1'b0;
    case (i_op)
      OP_RTYPE: begin
        case (i_funct)
          FN_ADDU: begin o_cls = C_RTYPE; o_alu_op = ALU_ADD; end
          FN_SUBU: begin o_cls = C_RTYPE; o_alu_op = ALU_SUB; end
          FN_AND:  begin o_cls = C_RTYPE; o_alu_op = ALU_AND; end
          FN_OR:   begin o_cls = C_RTYPE; o_alu_op = ALU_OR;  end
          FN_SLT:  begin o_cls = C_RTYPE; o_alu_op = ALU_SLT; end
          FN_JR:   o_cls = C_JR;
          default: o_cls = C_ILL;
        endcase
      end
      OP_ORI:   begin o_cls = C_ORI;   o_bsel = 1'b1; o_ext_op = EXT_ZERO; o_alu_op = ALU_OR;  end
      // lui relies on rs=$0 so OR passes the shifted immediate straight through.
      OP_LUI:   begin o_cls = C_LUI;   o_bsel = 1'b1; o_ext_op = EXT_LUI;  o_alu_op = ALU_OR;  end
      OP_ADDIU: begin o_cls = C_ADDIU; o_bsel = 1'b1; o_ext_op = EXT_SIGN; o_alu_op = ALU_ADD; end
      OP_LW:    begin o_cls = C_LW;    o_bsel = 1'b1; o_ext_op = EXT_SIGN; o_alu_op = ALU_ADD; end
      OP_SW:    begin o_cls = C_SW;    o_bsel = 1'b1; o_ext_op = EXT_SIGN; o_alu_op = ALU_ADD; end
      OP_BEQ:   begin o_cls = C_BEQ;   o_alu_op = ALU_SUB; end
      OP_J:     o_cls = C_J;
      OP_JAL:   o_cls = C_JAL;
      default:  o_cls = C_ILL;
    endcase
  end

  assign o_illegal = (o_cls == C_ILL);

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM with retired-instruction counter.
// Optional MC_ILL_TRAP_EN: illegal decode parks the FSM in S_HALT until reset.
module mc_ctrl
  import mc_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter bit RST_PC_HOLD = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  output logic             PCWr,
  output logic [1:0]       NPCOp,
  output logic             IRWr,
  output logic             RFWr,
  output logic [1:0]       GPRSel,
  output logic [1:0]       WDSel,
  output logic             BSel,
  output logic [1:0]       EXTOp,
  output logic [2:0]       ALUOp,
  output logic             DMWr,
  output logic             instr_done,
  output logic [CNT_W-1:0] instret,
  output logic             illegal
);

  state_t           r_state;
  state_t           w_next;
  logic             r_illegal;
  logic [CNT_W-1:0] r_instret;

  cls_t       w_cls;
  logic [2:0] w_alu_op;
  logic [1:0] w_ext_op;
  logic       w_bsel;
  logic       w_dec_illegal;
  logic       w_pcwr, w_irwr, w_rfwr, w_dmwr, w_done, w_hold;

  mc_decode u_decode (
    .i_op      (op),
    .i_funct   (funct),
    .o_cls     (w_cls),
    .o_alu_op  (w_alu_op),
    .o_ext_op  (w_ext_op),
    .o_bsel    (w_bsel),
    .o_illegal (w_dec_illegal)
  );

  // Reset forces S_FETCH asynchronously; the hold masks its fetch enables too.
  assign w_hold = RST_PC_HOLD && !rst_n;

  always_comb begin
    w_next = r_state;
    w_pcwr = 1'b0;
    w_irwr = 1'b0;
    w_rfwr = 1'b0;
    w_dmwr = 1'b0;
    w_done = 1'b0;
    NPCOp  = NPC_PC4;
    GPRSel = GPR_RD;
    WDSel  = WD_ALU;
    BSel   = 1'b0;
    EXTOp  = EXT_ZERO;
    ALUOp  = ALU_ADD;
    case (r_state)
      S_FETCH: begin
        w_irwr = 1'b1;
        w_pcwr = 1'b1;
        w_next = S_DECODE;
      end
      S_DECODE: begin
        if (w_dec_illegal) begin
`ifdef MC_ILL_TRAP_EN
          w_next = S_HALT;
`else
          w_done = 1'b1;
          w_next = S_FETCH;
`endif
        end else begin
          case (w_cls)
            C_J:   begin w_pcwr = 1'b1; NPCOp = NPC_JUMP; w_done = 1'b1; w_next = S_FETCH; end
            C_JR:  begin w_pcwr = 1'b1; NPCOp = NPC_JR;   w_done = 1'b1; w_next = S_FETCH; end
            // PC already holds PC+4 here, so link and jump share one edge.
            C_JAL: begin
              w_pcwr = 1'b1; NPCOp = NPC_JUMP;
              w_rfwr = 1'b1; GPRSel = GPR_31; WDSel = WD_PC;
              w_done = 1'b1; w_next = S_FETCH;
            end
            default: w_next = S_EXE;
          endcase
        end
      end
      S_EXE: begin
        BSel  = w_bsel;
        EXTOp = w_ext_op;
        ALUOp = w_alu_op;
        case (w_cls)
          C_BEQ:      begin w_pcwr = zero; NPCOp = NPC_BR; w_done = 1'b1; w_next = S_FETCH; end
          C_LW, C_SW: w_next = S_MEM;
          default:    w_next = S_WB;
        endcase
      end
      S_MEM: begin
        if (w_cls == C_SW) begin
          w_dmwr = 1'b1;
          w_done = 1'b1;
          w_next = S_FETCH;
        end else begin
          w_next = S_WB;
        end
      end
      S_WB: begin
        w_rfwr = 1'b1;
        w_done = 1'b1;
        GPRSel = (w_cls == C_RTYPE) ? GPR_RD : GPR_RT;
        WDSel  = (w_cls == C_LW) ? WD_DM : WD_ALU;
        w_next = S_FETCH;
      end
`ifdef MC_ILL_TRAP_EN
      S_HALT: w_next = S_HALT;
`endif
      default: w_next = S_FETCH;
    endcase
  end

  assign PCWr       = w_pcwr & ~w_hold;
  assign IRWr       = w_irwr & ~w_hold;
  assign RFWr       = w_rfwr & ~w_hold;
  assign DMWr       = w_dmwr & ~w_hold;
  assign instr_done = w_done & ~w_hold;
  assign instret    = r_instret;
  assign illegal    = r_illegal;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_FETCH;
      r_illegal <= 1'b0;
      r_instret <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE && w_dec_illegal) r_illegal <= 1'b1;
      if (w_done) r_instret <= r_instret + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed self-checking bench for mc_ctrl; honours MC_ILL_TRAP_EN when defined.
module tb_mc_ctrl;
  import mc_pkg::*;

  localparam int CNT_W = 32;
  localparam int MAX_CYC = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [5:0]       op, funct;
  logic             zero;
  logic             PCWr, IRWr, RFWr, BSel, DMWr, instr_done, illegal;
  logic [1:0]       NPCOp, GPRSel, WDSel, EXTOp;
  logic [2:0]       ALUOp;
  logic [CNT_W-1:0] instret;

  typedef struct packed {
    logic       pcwr;
    logic [1:0] npc;
    logic       irwr;
    logic       rfwr;
    logic [1:0] gpr;
    logic [1:0] wd;
    logic       bsel;
    logic [1:0] ext;
    logic [2:0] alu;
    logic       dmwr;
    logic       done;
  } smp_t;

  smp_t smp [MAX_CYC];
  int   n_cyc;
  int   errors = 0;
  int   checks = 0;
  int   exp_ret = 0;

  mc_ctrl #(.CNT_W(CNT_W), .RST_PC_HOLD(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero),
    .PCWr(PCWr), .NPCOp(NPCOp), .IRWr(IRWr), .RFWr(RFWr), .GPRSel(GPRSel),
    .WDSel(WDSel), .BSel(BSel), .EXTOp(EXTOp), .ALUOp(ALUOp), .DMWr(DMWr),
    .instr_done(instr_done), .instret(instret), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Runs one instruction from S_FETCH, recording outputs each cycle at negedge+1.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z);
    op = o; funct = f; zero = z;
    #1;
    n_cyc = 0;
    for (int i = 0; i < MAX_CYC; i++) begin
      smp[i] = '{PCWr, NPCOp, IRWr, RFWr, GPRSel, WDSel, BSel, EXTOp, ALUOp, DMWr, instr_done};
      n_cyc = i + 1;
      if (instr_done === 1'b1) break;
      @(negedge clk); #1;
    end
    @(negedge clk); #1;
  endtask

  function automatic int count_rfwr();
    int c = 0;
    for (int i = 0; i < n_cyc; i++) if (smp[i].rfwr) c++;
    return c;
  endfunction

  function automatic int count_dmwr();
    int c = 0;
    for (int i = 0; i < n_cyc; i++) if (smp[i].dmwr) c++;
    return c;
  endfunction

  task automatic test_reset();
    logic [4:0] en;
    rst_n = 1'b0; op = OP_RTYPE; funct = FN_ADDU; zero = 1'b0;
    @(negedge clk); #1;
    en = {PCWr, IRWr, RFWr, DMWr, instr_done};
    checks++; if (en !== 5'b0) begin errors++; $display("FAIL reset_enables: got %b expected 00000", en); end
    checks++; if (instret !== '0) begin errors++; $display("FAIL reset_instret: got %0d expected 0", instret); end
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal: got %b expected 0", illegal); end
    rst_n = 1'b1; #1;
    checks++; if ({IRWr, PCWr} !== 2'b11) begin errors++; $display("FAIL reset_first_fetch: got %b expected 11", {IRWr, PCWr}); end
    @(negedge clk); #1;
    @(negedge clk); #1;
    rst_n = 1'b0; #1;
    en = {PCWr, IRWr, RFWr, DMWr, instr_done};
    checks++; if (en !== 5'b0) begin errors++; $display("FAIL reset_mid_exe_enables: got %b expected 00000", en); end
    @(negedge clk); #1;
    checks++; if (instret !== '0) begin errors++; $display("FAIL reset_mid_exe_instret: got %0d expected 0", instret); end
    rst_n = 1'b1; #1;
    checks++; if ({IRWr, PCWr, RFWr} !== 3'b110) begin errors++; $display("FAIL reset_restart_fetch: got %b expected 110", {IRWr, PCWr, RFWr}); end
  endtask

  task automatic test_addu();
    run_instr(OP_RTYPE, FN_ADDU, 1'b0); exp_ret++;
    checks++; if (n_cyc !== 4) begin errors++; $display("FAIL addu_cycles: got %0d expected 4", n_cyc); end
    checks++; if ({smp[0].irwr, smp[0].pcwr, smp[0].npc} !== 4'b1100) begin errors++; $display("FAIL addu_fetch: got %b expected 1100", {smp[0].irwr, smp[0].pcwr, smp[0].npc}); end
    checks++; if ({smp[2].bsel, smp[2].alu} !== {1'b0, ALU_ADD}) begin errors++; $display("FAIL addu_exe: got %b expected 0000", {smp[2].bsel, smp[2].alu}); end
    checks++; if ({smp[3].rfwr, smp[3].gpr, smp[3].wd} !== 5'b10000) begin errors++; $display("FAIL addu_wb: got %b expected 10000", {smp[3].rfwr, smp[3].gpr, smp[3].wd}); end
    checks++; if (count_rfwr() !== 1) begin errors++; $display("FAIL addu_rfwr_count: got %0d expected 1", count_rfwr()); end
    checks++; if (instret !== CNT_W'(exp_ret)) begin errors++; $display("FAIL addu_instret: got %0d expected %0d", instret, exp_ret); end
  endtask

  task automatic test_rtype_alu();
    logic [5:0] fn_tab  [4] = '{FN_SUBU, FN_AND, FN_OR, FN_SLT};
    logic [2:0] alu_tab [4] = '{ALU_SUB, ALU_AND, ALU_OR, ALU_SLT};
    for (int k = 0; k < 4; k++) begin
      run_instr(OP_RTYPE, fn_tab[k], 1'b0); exp_ret++;
      checks++; if (smp[2].alu !== alu_tab[k]) begin errors++; $display("FAIL rtype_alu[%0d]: got %b expected %b", k, smp[2].alu, alu_tab[k]); end
      checks++; if ({n_cyc[3:0], smp[3].rfwr, smp[3].gpr} !== {4'd4, 1'b1, GPR_RD}) begin errors++; $display("FAIL rtype_wb[%0d]: got cycles=%0d rfwr=%b gpr=%b expected 4/1/00", k, n_cyc, smp[3].rfwr, smp[3].gpr); end
    end
  endtask

  task automatic test_imm();
    logic [5:0] op_tab  [3] = '{OP_ORI, OP_LUI, OP_ADDIU};
    logic [1:0] ext_tab [3] = '{EXT_ZERO, EXT_LUI, EXT_SIGN};
    logic [2:0] alu_tab [3] = '{ALU_OR, ALU_OR, ALU_ADD};
    for (int k = 0; k < 3; k++) begin
      run_instr(op_tab[k], 6'h15, 1'b0); exp_ret++;
      checks++; if ({smp[2].bsel, smp[2].ext, smp[2].alu} !== {1'b1, ext_tab[k], alu_tab[k]}) begin errors++; $display("FAIL imm_exe[%0d]: got %b expected %b", k, {smp[2].bsel, smp[2].ext, smp[2].alu}, {1'b1, ext_tab[k], alu_tab[k]}); end
      checks++; if ({n_cyc[3:0], smp[3].rfwr, smp[3].gpr, smp[3].wd} !== {4'd4, 1'b1, GPR_RT, WD_ALU}) begin errors++; $display("FAIL imm_wb[%0d]: got cycles=%0d rfwr=%b gpr=%b wd=%b expected 4/1/01/00", k, n_cyc, smp[3].rfwr, smp[3].gpr, smp[3].wd); end
    end
  endtask

  task automatic test_lw();
    run_instr(OP_LW, 6'h00, 1'b0); exp_ret++;
    checks++; if (n_cyc !== 5) begin errors++; $display("FAIL lw_cycles: got %0d expected 5", n_cyc); end
    checks++; if ({smp[2].ext, smp[2].bsel, smp[2].alu} !== {EXT_SIGN, 1'b1, ALU_ADD}) begin errors++; $display("FAIL lw_exe: got %b expected 011000", {smp[2].ext, smp[2].bsel, smp[2].alu}); end
    checks++; if ({smp[4].rfwr, smp[4].gpr, smp[4].wd} !== 5'b10101) begin errors++; $display("FAIL lw_wb: got %b expected 10101", {smp[4].rfwr, smp[4].gpr, smp[4].wd}); end
    checks++; if (count_dmwr() !== 0) begin errors++; $display("FAIL lw_dmwr: got %0d expected 0", count_dmwr()); end
  endtask

  task automatic test_sw();
    run_instr(OP_SW, 6'h00, 1'b0); exp_ret++;
    checks++; if ({n_cyc[3:0], smp[3].dmwr} !== {4'd4, 1'b1}) begin errors++; $display("FAIL sw_mem: got cycles=%0d dmwr=%b expected 4/1", n_cyc, smp[3].dmwr); end
    checks++; if (count_rfwr() !== 0) begin errors++; $display("FAIL sw_rfwr: got %0d expected 0", count_rfwr()); end
  endtask

  task automatic test_beq();
    for (int z = 1; z >= 0; z--) begin
      run_instr(OP_BEQ, 6'h00, z[0]); exp_ret++;
      checks++; if ({n_cyc[3:0], smp[2].pcwr, smp[2].npc, smp[2].alu, smp[2].bsel} !== {4'd3, z[0], NPC_BR, ALU_SUB, 1'b0}) begin
        errors++; $display("FAIL beq_z%0d: got cycles=%0d pcwr=%b npc=%b alu=%b bsel=%b expected 3/%0d/01/001/0", z, n_cyc, smp[2].pcwr, smp[2].npc, smp[2].alu, smp[2].bsel, z);
      end
      checks++; if (IRWr !== 1'b1) begin errors++; $display("FAIL beq_z%0d_refetch: got IRWr=%b expected 1", z, IRWr); end
    end
  endtask

  task automatic test_jumps();
    run_instr(OP_JAL, 6'h00, 1'b0); exp_ret++;
    checks++; if ({n_cyc[3:0], smp[1].pcwr, smp[1].npc, smp[1].rfwr, smp[1].gpr, smp[1].wd} !== {4'd2, 1'b1, NPC_JUMP, 1'b1, GPR_31, WD_PC}) begin
      errors++; $display("FAIL jal_decode: got cycles=%0d pcwr=%b npc=%b rfwr=%b gpr=%b wd=%b expected 2/1/10/1/10/10", n_cyc, smp[1].pcwr, smp[1].npc, smp[1].rfwr, smp[1].gpr, smp[1].wd);
    end
    checks++; if (IRWr !== 1'b1) begin errors++; $display("FAIL jal_refetch: got IRWr=%b expected 1", IRWr); end
    run_instr(OP_J, 6'h00, 1'b0); exp_ret++;
    checks++; if ({n_cyc[3:0], smp[1].pcwr, smp[1].npc, smp[1].rfwr} !== {4'd2, 1'b1, NPC_JUMP, 1'b0}) begin errors++; $display("FAIL j_decode: got cycles=%0d pcwr=%b npc=%b rfwr=%b expected 2/1/10/0", n_cyc, smp[1].pcwr, smp[1].npc, smp[1].rfwr); end
    run_instr(OP_RTYPE, FN_JR, 1'b0); exp_ret++;
    checks++; if ({n_cyc[3:0], smp[1].pcwr, smp[1].npc, smp[1].rfwr} !== {4'd2, 1'b1, NPC_JR, 1'b0}) begin errors++; $display("FAIL jr_decode: got cycles=%0d pcwr=%b npc=%b rfwr=%b expected 2/1/11/0", n_cyc, smp[1].pcwr, smp[1].npc, smp[1].rfwr); end
    checks++; if (instret !== CNT_W'(exp_ret)) begin errors++; $display("FAIL instret_total: got %0d expected %0d", instret, exp_ret); end
  endtask

  task automatic test_illegal();
    int wr;
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL illegal_before: got %b expected 0", illegal); end
    run_instr(6'b111111, 6'h00, 1'b0);
    wr = count_rfwr() + count_dmwr();
    checks++; if (wr !== 0) begin errors++; $display("FAIL illegal_writes: got %0d expected 0", wr); end
    checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL illegal_set: got %b expected 1", illegal); end
`ifdef MC_ILL_TRAP_EN
    checks++; if (n_cyc !== MAX_CYC) begin errors++; $display("FAIL trap_no_done: got cycles=%0d expected %0d", n_cyc, MAX_CYC); end
    for (int i = 1; i < MAX_CYC; i++) begin
      checks++; if ({smp[i].irwr, smp[i].pcwr} !== 2'b00) begin errors++; $display("FAIL trap_hold[%0d]: got %b expected 00", i, {smp[i].irwr, smp[i].pcwr}); end
    end
    rst_n = 1'b0; #1;
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL trap_reset_clear: got %b expected 0", illegal); end
    @(negedge clk); rst_n = 1'b1; #1;
    checks++; if ({IRWr, PCWr} !== 2'b11) begin errors++; $display("FAIL trap_refetch: got %b expected 11", {IRWr, PCWr}); end
`else
    exp_ret++;
    checks++; if ({n_cyc[3:0], smp[1].done, smp[1].pcwr} !== {4'd2, 1'b1, 1'b0}) begin errors++; $display("FAIL illegal_nop: got cycles=%0d done=%b pcwr=%b expected 2/1/0", n_cyc, smp[1].done, smp[1].pcwr); end
    run_instr(OP_RTYPE, FN_ADDU, 1'b0); exp_ret++;
    checks++; if ({n_cyc[3:0], smp[3].rfwr} !== {4'd4, 1'b1}) begin errors++; $display("FAIL illegal_next_instr: got cycles=%0d rfwr=%b expected 4/1", n_cyc, smp[3].rfwr); end
    checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL illegal_sticky: got %b expected 1", illegal); end
    checks++; if (instret !== CNT_W'(exp_ret)) begin errors++; $display("FAIL illegal_instret: got %0d expected %0d", instret, exp_ret); end
`endif
  endtask

  initial begin
    test_reset();
    test_addu();
    test_rtype_alu();
    test_imm();
    test_lw();
    test_sw();
    test_beq();
    test_jumps();
    test_illegal();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
